vga_mode_seq: RTL

- Sequences a display-mode (resolution) change for the VGA pipeline.
- Per change: blanks the display, requests pixel-clock reconfiguration from the clock generator, waits for lock (with timeout/retry), sweeps the framebuffer to a clear colour, then re-enables the display.
- Also arbitrates the framebuffer write port between the pattern/client writer and its own clear engine.
- Sits between the board switches/clock generator and vga_top. Its framebuffer write port and clk_valid_i are in the clk_i domain.

---
 rtl/vga_mode_seq_if.sv | 25 ++
 rtl/vga_mode_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_seq_if.sv
// Client write port and framebuffer write port of the mode sequencer.
// master = client writer + framebuffer sink; slave = vga_mode_seq.
interface vga_mode_seq_if;
  logic [10:0] cl_addr_x;
  logic [10:0] cl_addr_y;
  logic [1:0]  cl_color;
  logic        cl_we;
  logic        cl_ready;
  logic [10:0] fb_addr_x;
  logic [10:0] fb_addr_y;
  logic [1:0]  fb_color;
  logic        fb_we;

  modport master (
    output cl_addr_x, cl_addr_y, cl_color, cl_we,
    input  cl_ready,
    input  fb_addr_x, fb_addr_y, fb_color, fb_we
  );

  modport slave (
    input  cl_addr_x, cl_addr_y, cl_color, cl_we,
    output cl_ready,
    output fb_addr_x, fb_addr_y, fb_color, fb_we
  );
endinterface

// File: rtl/vga_mode_seq.sv
// Display-mode change sequencer: blank, reconfigure pixel clock, wait for lock,
// clear the framebuffer, then hand the write port back to the client.
module vga_mode_seq #(
  parameter int         RES0_X       = 1280,
  parameter int         RES0_Y       = 1024,
  parameter int         RES1_X       = 800,
  parameter int         RES1_Y       = 600,
  parameter int         BLANK_CYCLES = 16,
  parameter int         LOCK_TIMEOUT = 4096,
  parameter logic [1:0] CLEAR_COLOR  = 2'b00
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        mode_sel_i,
  input  logic        clk_valid_i,
  output logic        clk_req_o,
  output logic        mode_o,
  output logic [10:0] res_x_o,
  output logic [10:0] res_y_o,
  output logic        vga_en_o,
  output logic        busy_o,
  output logic        lock_err_o,
  vga_mode_seq_if.slave wr
);

  // states: BLANK hold disabled | REQ clock request | WAIT_LOCK | CLEAR sweep | RUN
  typedef enum logic [2:0] {S_BLANK, S_REQ, S_WAIT_LOCK, S_CLEAR, S_RUN} state_t;

  localparam int CNT_MAX = (BLANK_CYCLES > LOCK_TIMEOUT) ? BLANK_CYCLES : LOCK_TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [10:0]   RX0 = 11'(RES0_X);
  localparam logic [10:0]   RY0 = 11'(RES0_Y);
  localparam logic [10:0]   RX1 = 11'(RES1_X);
  localparam logic [10:0]   RY1 = 11'(RES1_Y);

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [10:0]   r_x, r_y, w_x_nx, w_y_nx;
  logic          r_mode, w_mode_nx;
  logic [10:0]   r_res_x, r_res_y, w_res_x_nx, w_res_y_nx;
  logic          r_lock_err, w_lock_err_nx;
  logic          r_clk_req, r_vga_en, r_busy, r_cl_ready;
  logic [10:0]   r_fb_x, r_fb_y, w_fb_x_nx, w_fb_y_nx;
  logic [1:0]    r_fb_color, w_fb_color_nx;
  logic          r_fb_we, w_fb_we_nx;
  logic          w_last_x, w_last_y;

  assign w_last_x = (r_x == r_res_x - 11'd1);
  assign w_last_y = (r_y == r_res_y - 11'd1);

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_x_nx        = r_x;
    w_y_nx        = r_y;
    w_mode_nx     = r_mode;
    w_res_x_nx    = r_res_x;
    w_res_y_nx    = r_res_y;
    w_lock_err_nx = r_lock_err;
    w_fb_x_nx     = r_fb_x;
    w_fb_y_nx     = r_fb_y;
    w_fb_color_nx = r_fb_color;
    w_fb_we_nx    = 1'b0;
    case (r_state)
      S_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nx = S_REQ;
          w_cnt_nx   = '0;
          w_mode_nx  = mode_sel_i;
          w_res_x_nx = mode_sel_i ? RX1 : RX0;
          w_res_y_nx = mode_sel_i ? RY1 : RY0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_REQ: begin
        w_state_nx = S_WAIT_LOCK;
        w_cnt_nx   = '0;
      end
      S_WAIT_LOCK: begin
        if (clk_valid_i) begin
          // the first clear write is presented on the cycle CLEAR is entered
          w_state_nx    = S_CLEAR;
          w_x_nx        = '0;
          w_y_nx        = '0;
          w_fb_x_nx     = '0;
          w_fb_y_nx     = '0;
          w_fb_color_nx = CLEAR_COLOR;
          w_fb_we_nx    = 1'b1;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nx    = S_REQ;
          w_cnt_nx      = '0;
          w_lock_err_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_CLEAR: begin
        if (w_last_x && w_last_y) begin
          w_state_nx = S_RUN;
        end else begin
          w_x_nx        = w_last_x ? 11'd0 : r_x + 11'd1;
          w_y_nx        = w_last_x ? r_y + 11'd1 : r_y;
          w_fb_x_nx     = w_x_nx;
          w_fb_y_nx     = w_y_nx;
          w_fb_color_nx = CLEAR_COLOR;
          w_fb_we_nx    = 1'b1;
        end
      end
      S_RUN: begin
        w_fb_x_nx     = wr.cl_addr_x;
        w_fb_y_nx     = wr.cl_addr_y;
        w_fb_color_nx = wr.cl_color;
        w_fb_we_nx    = wr.cl_we;
        if (mode_sel_i != r_mode) begin
          w_state_nx = S_BLANK;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = S_BLANK;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state    <= S_BLANK;
      r_cnt      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_mode     <= 1'b0;
      r_res_x    <= RX0;
      r_res_y    <= RY0;
      r_lock_err <= 1'b0;
      r_clk_req  <= 1'b0;
      r_vga_en   <= 1'b0;
      r_busy     <= 1'b1;
      r_cl_ready <= 1'b0;
      r_fb_x     <= '0;
      r_fb_y     <= '0;
      r_fb_color <= '0;
      r_fb_we    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_x        <= w_x_nx;
      r_y        <= w_y_nx;
      r_mode     <= w_mode_nx;
      r_res_x    <= w_res_x_nx;
      r_res_y    <= w_res_y_nx;
      r_lock_err <= w_lock_err_nx;
      r_clk_req  <= (w_state_nx == S_REQ);
      r_vga_en   <= (w_state_nx == S_RUN);
      r_busy     <= (w_state_nx != S_RUN);
      r_cl_ready <= (w_state_nx == S_RUN);
      r_fb_x     <= w_fb_x_nx;
      r_fb_y     <= w_fb_y_nx;
      r_fb_color <= w_fb_color_nx;
      r_fb_we    <= w_fb_we_nx;
    end
  end

  assign clk_req_o    = r_clk_req;
  assign mode_o       = r_mode;
  assign res_x_o      = r_res_x;
  assign res_y_o      = r_res_y;
  assign vga_en_o     = r_vga_en;
  assign busy_o       = r_busy;
  assign lock_err_o   = r_lock_err;
  assign wr.cl_ready  = r_cl_ready;
  assign wr.fb_addr_x = r_fb_x;
  assign wr.fb_addr_y = r_fb_y;
  assign wr.fb_color  = r_fb_color;
  assign wr.fb_we     = r_fb_we;

endmodule
